// File: rtl/try_pkg.sv
// Shared types and constants for the two-sensor direction counter.
package try_pkg;

  localparam int            CNT_W   = 8;
  localparam logic [7:0]    CNT_MAX = 8'd255;

  // One-hot encoding so the state register drives zhuan1..3 directly.
  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    LAST_A = 3'b010,
    LAST_B = 3'b100
  } state_e;

  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] cnt,
                                                input logic             up);
    logic [CNT_W-1:0] r;
    r = cnt;
    if (up) begin
      if (cnt != CNT_MAX) r = cnt + 1'b1;
    end else begin
      if (cnt != '0) r = cnt - 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/try_if.sv
// Sensor inputs and board-level indicator outputs of the direction counter.
interface try_if;
  logic in, in1;
  logic k1, k2, a;
  logic zhuan1, zhuan2, zhuan3;
  logic p1, p2, p3, p4, p5, p6, p7, p8;
  logic h, c, d;

  modport slave (
    input  in, in1,
    output k1, k2, a, zhuan1, zhuan2, zhuan3,
           p1, p2, p3, p4, p5, p6, p7, p8, h, c, d
  );

  modport master (
    output in, in1,
    input  k1, k2, a, zhuan1, zhuan2, zhuan3,
           p1, p2, p3, p4, p5, p6, p7, p8, h, c, d
  );
endinterface

// File: rtl/sync_rise.sv
// 2-FF synchroniser plus history flop; emits the synchronised level and a
// one-cycle rise pulse.
module sync_rise (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = din;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~s3_q;

endmodule

// File: rtl/try_unit.sv
// Direction counter: A-then-B is an entry, B-then-A an exit; saturating
// 8-bit occupancy count with registered status and event outputs.
module try_unit
  import try_pkg::*;
(
  input  logic  sys_clk,
  input  logic  sys_rst,
  try_if.slave  bus
);

  logic lvl_a, rise_a, lvl_b, rise_b;

  sync_rise u_sync_a (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .din   (bus.in),
    .level (lvl_a),
    .rise  (rise_a)
  );

  sync_rise u_sync_b (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .din   (bus.in1),
    .level (lvl_b),
    .rise  (rise_b)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             k1_q, k1_d, k2_q, k2_d;
  logic             a_q, a_d, h_q, h_d, c_q, c_d, d_q, d_d;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k1_q    <= 1'b0;
      k2_q    <= 1'b0;
      a_q     <= 1'b0;
      h_q     <= 1'b0;
      c_q     <= 1'b1;
      d_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k1_q    <= k1_d;
      k2_q    <= k2_d;
      a_q     <= a_d;
      h_q     <= h_d;
      c_q     <= c_d;
      d_q     <= d_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k1_d    = 1'b0;
    k2_d    = 1'b0;
    cnt_d   = cnt_q;
    d_d     = d_q;
    a_d     = lvl_a & lvl_b;

    // Simultaneous rises are ambiguous: forget history, count nothing.
    case ({rise_a, rise_b})
      2'b11: state_d = IDLE;
      2'b10: begin
        if (state_q == LAST_B) k2_d = 1'b1;
        state_d = LAST_A;
      end
      2'b01: begin
        if (state_q == LAST_A) k1_d = 1'b1;
        state_d = LAST_B;
      end
      default: state_d = state_q;
    endcase

    if (k1_d) begin
      cnt_d = sat_step(cnt_q, 1'b1);
      d_d   = 1'b1;
    end else if (k2_d) begin
      cnt_d = sat_step(cnt_q, 1'b0);
      d_d   = 1'b0;
    end

    // Flags follow the next count so they line up with the count register.
    h_d = (cnt_d == CNT_MAX);
    c_d = (cnt_d == '0);
  end

  assign bus.k1     = k1_q;
  assign bus.k2     = k2_q;
  assign bus.a      = a_q;
  assign bus.zhuan1 = state_q[0];
  assign bus.zhuan2 = state_q[1];
  assign bus.zhuan3 = state_q[2];
  assign bus.p1     = cnt_q[0];
  assign bus.p2     = cnt_q[1];
  assign bus.p3     = cnt_q[2];
  assign bus.p4     = cnt_q[3];
  assign bus.p5     = cnt_q[4];
  assign bus.p6     = cnt_q[5];
  assign bus.p7     = cnt_q[6];
  assign bus.p8     = cnt_q[7];
  assign bus.h      = h_q;
  assign bus.c      = c_q;
  assign bus.d      = d_q;

endmodule

// File: tb/tb_try_unit.sv
// Scoreboard bench for try_unit: stimulus queues expected events, a monitor
// checks every k1/k2 pulse against the queue.
module tb_try_unit;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  try_if u_if ();

  try_unit dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (u_if.slave)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    bit entry;
    int cnt;
    int at;
  } ev_t;

  ev_t q[$];
  int  ms   = 0;   // 0 idle, 1 last A, 2 last B
  int  mcnt = 0;

  function automatic void chk(string name, int got, int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d cyc=%0d", name, got, exp, cyc);
    end
  endfunction

  function automatic int cnt_of();
    return {u_if.p8, u_if.p7, u_if.p6, u_if.p5,
            u_if.p4, u_if.p3, u_if.p2, u_if.p1};
  endfunction

  // Expected pulse appears at the negedge three cycles after the drive negedge.
  function automatic void model(bit ra, bit rb);
    if (ra && rb) ms = 0;
    else if (ra) begin
      if (ms == 2) begin
        mcnt = (mcnt == 0) ? 0 : mcnt - 1;
        q.push_back('{1'b0, mcnt, cyc + 3});
      end
      ms = 1;
    end else if (rb) begin
      if (ms == 1) begin
        mcnt = (mcnt == 255) ? 255 : mcnt + 1;
        q.push_back('{1'b1, mcnt, cyc + 3});
      end
      ms = 2;
    end
  endfunction

  task automatic do_rise(bit ra, bit rb);
    @(negedge sys_clk);
    if (ra) u_if.in  = 1'b1;
    if (rb) u_if.in1 = 1'b1;
    model(ra, rb);
    repeat (3) @(negedge sys_clk);
    u_if.in  = 1'b0;
    u_if.in1 = 1'b0;
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    ms   = 0;
    mcnt = 0;
    @(negedge sys_clk);
  endtask

  task automatic chk_state(string name, int exp_state);
    chk({name, "_z1"}, u_if.zhuan1, exp_state == 0);
    chk({name, "_z2"}, u_if.zhuan2, exp_state == 1);
    chk({name, "_z3"}, u_if.zhuan3, exp_state == 2);
  endtask

  always @(negedge sys_clk) begin
    if (u_if.k1 || u_if.k2) begin
      ev_t e;
      if (u_if.k1 && u_if.k2) chk("k1_k2_exclusive", 1, 0);
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse k1=%0b k2=%0b cyc=%0d", u_if.k1, u_if.k2, cyc);
      end else begin
        e = q.pop_front();
        chk("ev_kind",  u_if.k1, e.entry);
        chk("ev_cnt",   cnt_of(), e.cnt);
        chk("ev_d",     u_if.d, e.entry);
        chk("ev_cycle", cyc, e.at);
        chk("ev_h",     u_if.h, e.cnt == 255);
        chk("ev_c",     u_if.c, e.cnt == 0);
      end
    end
  end

  initial begin
    u_if.in  = 1'b0;
    u_if.in1 = 1'b0;

    // Reset with inputs low
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk_state("rst", 0);
    chk("rst_cnt", cnt_of(), 0);
    chk("rst_c", u_if.c, 1);
    chk("rst_h", u_if.h, 0);
    chk("rst_d", u_if.d, 0);
    chk("rst_k1", u_if.k1, 0);
    chk("rst_k2", u_if.k2, 0);
    chk("rst_a", u_if.a, 0);

    // A high, B joins 40 ns later, A drops
    @(negedge sys_clk);
    u_if.in = 1'b1;
    model(1, 0);
    repeat (4) @(negedge sys_clk);
    u_if.in1 = 1'b1;
    model(0, 1);
    repeat (3) @(negedge sys_clk);
    chk("alarm_high", u_if.a, 1);
    u_if.in = 1'b0;
    repeat (4) @(negedge sys_clk);
    chk("alarm_low", u_if.a, 0);
    chk_state("entry1", 2);
    chk("entry1_cnt", cnt_of(), 1);
    chk("entry1_d", u_if.d, 1);
    u_if.in1 = 1'b0;
    repeat (4) @(negedge sys_clk);

    // Alternating A/B, five pairs
    for (int i = 0; i < 5; i++) begin
      do_rise(1, 0);
      chk("alt_cnt_a", cnt_of(), mcnt);
      do_rise(0, 1);
      chk("alt_cnt_b", cnt_of(), mcnt);
    end

    // Repeated A rises: only the first (from LAST_B) is an exit
    do_rise(1, 0);
    for (int i = 0; i < 3; i++) do_rise(1, 0);
    chk_state("rep_a", 1);
    chk("rep_a_cnt", cnt_of(), 0);

    // Fill to 255 via A,B entries separated by a simultaneous rise
    while (mcnt < 255) begin
      do_rise(1, 0);
      do_rise(0, 1);
      do_rise(1, 1);
    end
    chk("full_cnt", cnt_of(), 255);
    chk("full_h", u_if.h, 1);
    do_rise(1, 0);
    do_rise(0, 1);
    chk("sat_hi_cnt", cnt_of(), 255);
    chk("sat_hi_h", u_if.h, 1);
    chk("sat_hi_c", u_if.c, 0);

    // From 0, one exit saturates at 0
    do_reset();
    do_rise(0, 1);
    do_rise(1, 0);
    chk("sat_lo_cnt", cnt_of(), 0);
    chk("sat_lo_c", u_if.c, 1);
    chk("sat_lo_d", u_if.d, 0);
    chk_state("sat_lo", 1);

    // Simultaneous rises
    do_rise(1, 1);
    chk_state("simul", 0);
    chk("simul_cnt", cnt_of(), 0);

    // Reset mid-sequence from LAST_A
    do_rise(1, 0);
    chk_state("pre_rst", 1);
    do_reset();
    chk_state("post_rst", 0);
    do_rise(0, 1);
    chk_state("post_rst_b", 2);
    chk("post_rst_cnt", cnt_of(), 0);

    repeat (10) @(negedge sys_clk);
    chk("pending_events", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
